// File: rtl/drum_sector_decoder.sv
// Drum sector-address decoder: acquires word framing from the Z2 mark track,
// assembles the serial Z3 address and reports sequenced, index-checked sectors.
module drum_sector_decoder #(
    parameter int LOCK_WORDS = 2
) (
    input  logic       Z1,
    input  logic       RST,
    input  logic       Z2,
    input  logic       Z3,
    input  logic [6:0] TGT,
    output logic [5:0] BITNO,
    output logic [6:0] ADR,
    output logic       ADR_VLD,
    output logic       INDEX,
    output logic       LOCK,
    output logic       MATCH,
    output logic       ERR
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_CNT = 3'(LOCK_WORDS);

    state_t     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic [5:0] bit_q, bit_d;
    logic [6:0] asm_q, asm_d;
    logic [6:0] prev_q, prev_d;
    logic       prev_vld_q, prev_vld_d;
    logic [2:0] good_q, good_d;
    logic [6:0] adr_q, adr_d;
    logic       index_q, index_d;
    logic       adr_vld_q, adr_vld_d;
    logic       match_q, match_d;
    logic       err_q, err_d;

    logic [5:0] bit_next;
    logic [2:0] good_inc;
    logic       idx_ok, seq_ok, lock_now, fail;

    // Expected level of the word-mark track at each bit position of a word.
    function automatic logic z2_expected(input logic [5:0] b);
        return ((b >= 6'd31) && (b <= 6'd33)) || (b >= 6'd38);
    endfunction

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        bit_d      = bit_q;
        asm_d      = asm_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        good_d     = good_q;
        adr_d      = adr_q;
        index_d    = index_q;
        match_d    = match_q;
        adr_vld_d  = 1'b0;
        err_d      = 1'b0;
        fail       = 1'b0;

        bit_next = (bit_q == 6'd39) ? 6'd0 : bit_q + 6'd1;
        good_inc = good_q + 3'd1;
        idx_ok   = (Z3 == (asm_q == 7'd0));
        seq_ok   = !prev_vld_q || (asm_q == prev_q + 7'd1);
        lock_now = (state_q == LOCKED) || (good_inc >= LOCK_CNT);

        case (state_q)
            HUNT: begin
                if (Z2) begin
                    run_d = 4'd0;
                    // A mark after a long quiet run can only be the start of the bit-31 group.
                    if (run_q >= 4'd8) begin
                        state_d    = SYNC;
                        bit_d      = 6'd31;
                        good_d     = 3'd0;
                        prev_vld_d = 1'b0;
                    end
                end else if (run_q < 4'd8) begin
                    run_d = run_q + 4'd1;
                end
            end
            SYNC, LOCKED: begin
                bit_d = bit_next;
                if (Z2 != z2_expected(bit_next)) begin
                    fail = 1'b1;
                end else if ((bit_next >= 6'd32) && (bit_next <= 6'd38)) begin
                    asm_d = {Z3, asm_q[6:1]};
                end else if (bit_next == 6'd39) begin
                    if (!(idx_ok && seq_ok)) begin
                        fail = 1'b1;
                    end else begin
                        prev_d     = asm_q;
                        prev_vld_d = 1'b1;
                        if (state_q == SYNC) begin
                            good_d = good_inc;
                        end
                        if (lock_now) begin
                            state_d   = LOCKED;
                            adr_d     = asm_q;
                            index_d   = Z3;
                            adr_vld_d = 1'b1;
                            match_d   = (asm_q == TGT);
                        end
                    end
                end
                if (fail) begin
                    state_d    = HUNT;
                    run_d      = 4'd0;
                    bit_d      = 6'd0;
                    good_d     = 3'd0;
                    prev_vld_d = 1'b0;
                    match_d    = 1'b0;
                    err_d      = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
                run_d   = 4'd0;
                bit_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge Z1 or posedge RST) begin
        if (RST) begin
            state_q    <= HUNT;
            run_q      <= 4'd0;
            bit_q      <= 6'd0;
            asm_q      <= 7'd0;
            prev_q     <= 7'd0;
            prev_vld_q <= 1'b0;
            good_q     <= 3'd0;
            adr_q      <= 7'd0;
            index_q    <= 1'b0;
            adr_vld_q  <= 1'b0;
            match_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            bit_q      <= bit_d;
            asm_q      <= asm_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            good_q     <= good_d;
            adr_q      <= adr_d;
            index_q    <= index_d;
            adr_vld_q  <= adr_vld_d;
            match_q    <= match_d;
            err_q      <= err_d;
        end
    end

    assign BITNO   = bit_q;
    assign ADR     = adr_q;
    assign ADR_VLD = adr_vld_q;
    assign INDEX   = index_q;
    assign LOCK    = (state_q == LOCKED);
    assign MATCH   = match_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_drum_sector_decoder.sv
// Scoreboard bench for drum_sector_decoder: a word-level reference model predicts
// per-edge LOCK/MATCH/BITNO and the ADR_VLD/ERR events the monitor must see.
module tb_drum_sector_decoder;

    localparam int LW = 2;

    logic       Z1 = 1'b0;
    logic       RST = 1'b1;
    logic       Z2 = 1'b0;
    logic       Z3 = 1'b0;
    logic [6:0] TGT = 7'd0;
    logic [5:0] BITNO;
    logic [6:0] ADR;
    logic       ADR_VLD, INDEX, LOCK, MATCH, ERR;

    drum_sector_decoder #(.LOCK_WORDS(LW)) dut (
        .Z1(Z1), .RST(RST), .Z2(Z2), .Z3(Z3), .TGT(TGT),
        .BITNO(BITNO), .ADR(ADR), .ADR_VLD(ADR_VLD), .INDEX(INDEX),
        .LOCK(LOCK), .MATCH(MATCH), .ERR(ERR)
    );

    always #5 Z1 = ~Z1;

    typedef struct {
        bit lock;
        bit match;
        bit vld;
        bit err;
        int bitno;
    } lvl_t;

    typedef struct {
        bit err;
        int adr;
        bit idx;
    } evt_t;

    lvl_t lvl_q[$];
    evt_t evt_q[$];
    int   checks = 0;
    int   failures = 0;
    int   tgt_v = 0;

    // Reference model state (word-level view of the stream)
    bit        m_framed, m_locked, m_match, m_have_prev, m_idx;
    int        m_pos, m_prev, m_good, m_adr;
    int        m_z3[40];
    bit        hist[$];
    bit [39:0] z2pat;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bitno"}, BITNO, 0);
        chk({tag, "_adr"}, ADR, 0);
        chk({tag, "_adr_vld"}, ADR_VLD, 0);
        chk({tag, "_index"}, INDEX, 0);
        chk({tag, "_lock"}, LOCK, 0);
        chk({tag, "_match"}, MATCH, 0);
        chk({tag, "_err"}, ERR, 0);
    endtask

    function automatic bit last8_zero();
        if (hist.size() < 8) return 1'b0;
        for (int i = hist.size() - 8; i < hist.size(); i++)
            if (hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_framed = 0; m_locked = 0; m_match = 0; m_have_prev = 0;
        m_pos = 0; m_prev = 0; m_good = 0; m_adr = 0; m_idx = 0;
        hist.delete();
    endtask

    task automatic model_step(input bit z2, input bit z3, input int tgt);
        lvl_t l;
        evt_t e;
        bit   lose;
        bit   acc;
        int   a;
        lose = 0;
        acc = 0;
        if (!m_framed) begin
            if (z2 && last8_zero()) begin
                m_framed = 1; m_pos = 31; m_good = 0; m_have_prev = 0;
                hist.delete();
            end else begin
                hist.push_back(z2);
                if (hist.size() > 8) void'(hist.pop_front());
            end
        end else begin
            m_pos = (m_pos + 1) % 40;
            if (z2 != z2pat[m_pos]) begin
                lose = 1;
            end else begin
                m_z3[m_pos] = int'(z3);
                if (m_pos == 39) begin
                    a = 0;
                    for (int i = 0; i < 7; i++) a += m_z3[32 + i] << i;
                    if ((z3 != (a == 0)) || (m_have_prev && a != (m_prev + 1) % 128)) begin
                        lose = 1;
                    end else begin
                        m_prev = a; m_have_prev = 1; m_good++;
                        if (m_good >= LW) begin
                            m_locked = 1; m_adr = a; m_idx = z3;
                            m_match = (a == tgt); acc = 1;
                        end
                    end
                end
            end
        end
        if (lose) begin
            m_framed = 0; m_locked = 0; m_match = 0;
            hist.delete();
        end
        l = '{m_locked, m_match, acc, lose, m_pos};
        lvl_q.push_back(l);
        if (acc || lose) begin
            e = '{lose, m_adr, m_idx};
            evt_q.push_back(e);
        end
    endtask

    task automatic drive(input bit z2, input bit z3);
        @(negedge Z1);
        Z2 = z2;
        Z3 = z3;
        TGT = tgt_v[6:0];
        model_step(z2, z3, tgt_v);
    endtask

    task automatic reset_pulse(input string tag);
        @(posedge Z1);
        #3 RST = 1'b1;
        #1 chk_all_zero(tag);
        model_reset();
        repeat (2) @(posedge Z1);
        #3 RST = 1'b0;
    endtask

    // One 40-bit word; optional Z2 flip, wrong index, reset pulse and TGT change
    task automatic send_word(input int addr, input int flip_bit, input bit idx_bad,
                             input int rst_bit, input int tgt_bit, input int tgt_new);
        bit z2, z3;
        for (int b = 0; b < 40; b++) begin
            z2 = z2pat[b];
            if (b == flip_bit) z2 = ~z2;
            if (b >= 32 && b <= 38) z3 = ((addr >> (b - 32)) & 1) != 0;
            else if (b == 39) z3 = (addr == 0) ^ idx_bad;
            else z3 = ($urandom_range(0, 1) == 1);
            if (b == tgt_bit) tgt_v = tgt_new;
            if (b == rst_bit) reset_pulse("rst_mid_word");
            else drive(z2, z3);
        end
    endtask

    // Monitor: per-edge levels from lvl_q, events popped whenever the DUT pulses
    initial begin
        lvl_t l;
        evt_t e;
        forever begin
            @(posedge Z1);
            #2;
            if (lvl_q.size() > 0) begin
                l = lvl_q.pop_front();
                chk("lock", LOCK, l.lock);
                chk("match", MATCH, l.match);
                chk("adr_vld", ADR_VLD, l.vld);
                chk("err", ERR, l.err);
                if (l.lock) chk("bitno", BITNO, l.bitno);
            end
            if (ADR_VLD || ERR) begin
                if (evt_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = evt_q.pop_front();
                    chk("evt_kind_err", ERR, e.err);
                    chk("evt_adr", ADR, e.adr);
                    chk("evt_index", INDEX, e.idx);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        for (int i = 0; i < 40; i++) z2pat[i] = ((i >= 31 && i <= 33) || i >= 38);
        model_reset();

        #1 chk_all_zero("reset");
        @(posedge Z1);
        #3 RST = 1'b0;

        // Acquire on 5, lock on 6; TGT=10 gives one word of MATCH
        tgt_v = 10;
        for (int a = 5; a <= 12; a++) send_word(a, -1, 0, -1, -1, 0);

        // Spurious Z2 at bit 20, resync in the same word, then wrap 127->0
        send_word(123, 20, 0, -1, -1, 0);
        for (int a = 124; a <= 130; a++) send_word(a % 128, -1, 0, -1, -1, 0);

        // Sequence gap 2 -> 4, then relock
        send_word(4, -1, 0, -1, -1, 0);
        send_word(5, -1, 0, -1, -1, 0);
        send_word(6, -1, 0, -1, -1, 0);

        // Address 0 with index clear; nonzero address with index set
        send_word(126, -1, 0, -1, -1, 0);
        send_word(127, -1, 0, -1, -1, 0);
        send_word(0, -1, 1, -1, -1, 0);
        send_word(1, -1, 0, -1, -1, 0);
        send_word(2, -1, 0, -1, -1, 0);
        send_word(3, -1, 1, -1, -1, 0);
        send_word(4, -1, 0, -1, -1, 0);
        send_word(5, -1, 0, -1, 20, 6);

        // Reset pulse at bit 35 while locked, then relock
        send_word(6, -1, 0, 35, -1, 0);
        for (int a = 7; a <= 10; a++) send_word(a, -1, 0, -1, -1, 0);

        // Randomized stream with occasional faults and TGT changes
        cur = $urandom_range(0, 127);
        for (int w = 0; w < 60; w++) begin
            int r;
            int flip;
            bit ib;
            int tb;
            int tn;
            r = $urandom_range(0, 9);
            flip = -1; ib = 0; tb = -1; tn = 0;
            if (r == 0) flip = $urandom_range(0, 39);
            else if (r == 1) ib = 1;
            else if (r == 2) cur = $urandom_range(0, 127);
            if ($urandom_range(0, 2) == 0) begin
                tb = $urandom_range(0, 39);
                tn = ($urandom_range(0, 1) == 1) ? cur : $urandom_range(0, 127);
            end
            send_word(cur, flip, ib, -1, tb, tn);
            cur = (cur + 1) % 128;
        end

        @(posedge Z1);
        #5;
        chk("events_outstanding", evt_q.size(), 0);
        chk("levels_outstanding", lvl_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
